// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm
// Miss-handling control FSM for the direct-mapped data cache. Hits are
// served combinationally from IDLE. A miss stalls the core, writes back the
// victim block if it is dirty, refills the block one beat at a time, spends
// one UPDATE cycle, and then returns to IDLE so the held request hits.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_rd_req/wr_req   core load/store request (store wins if both are set)
//   hit, dirty          tag-array lookup for the current index/tag
//   mem_ready           per-beat acknowledge from main memory
//   stall               freeze the core pipeline
//   tag_replace, valid_out, dirty_out   tag-array write controls
//   data_wr_en, data_src_sel            data-array write enable / source
//   mem_rd, mem_wr, mem_addr_sel        memory burst handshake and address
//   beat_idx            word offset of the current memory beat
module cache_ctrl_fsm #(
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_rd_req,
  input  logic             cpu_wr_req,
  input  logic             hit,
  input  logic             dirty,
  input  logic             mem_ready,
  output logic             stall,
  output logic             tag_replace,
  output logic             valid_out,
  output logic             dirty_out,
  output logic             data_wr_en,
  output logic             data_src_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             mem_addr_sel,
  output logic [CNT_W-1:0] beat_idx
);

  typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE, UPDATE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_beat_cnt;

  logic w_req;
  logic w_last;

  assign w_req  = cpu_rd_req | cpu_wr_req;
  assign w_last = (r_beat_cnt == CNT_W'(BLOCK_WORDS - 1));

  // BLOCK_WORDS is a power of two, so the beat counter wraps to 0 on its own
  // after the last beat of each burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !hit) r_state <= dirty ? WRITE_BACK : ALLOCATE;
        end
        WRITE_BACK: begin
          if (mem_ready) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last) r_state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last) r_state <= UPDATE;
          end
        end
        default: r_state <= IDLE;  // UPDATE
      endcase
    end
  end

  // Outputs are decoded from state and live inputs: a hit or a memory beat
  // must act in the same cycle. Gating with rst keeps every output at 0 while
  // reset is held, even though IDLE with a pending request would otherwise
  // raise stall.
  always_comb begin
    stall        = 1'b0;
    tag_replace  = 1'b0;
    valid_out    = 1'b0;
    dirty_out    = 1'b0;
    data_wr_en   = 1'b0;
    data_src_sel = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr_sel = 1'b0;
    beat_idx     = r_beat_cnt;
    if (rst) begin
      beat_idx = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && hit) begin
            if (cpu_wr_req) begin
              data_wr_en  = 1'b1;
              tag_replace = 1'b1;
              valid_out   = 1'b1;
              dirty_out   = 1'b1;
            end
          end else if (w_req) begin
            stall = 1'b1;
          end
        end
        WRITE_BACK: begin
          stall        = 1'b1;
          mem_wr       = 1'b1;
          mem_addr_sel = 1'b1;
        end
        ALLOCATE: begin
          stall        = 1'b1;
          mem_rd       = 1'b1;
          data_src_sel = 1'b1;
          data_wr_en   = mem_ready;
          // The line becomes valid only with the final beat, so a reset
          // mid-refill leaves it invalid.
          if (mem_ready && w_last) begin
            tag_replace = 1'b1;
            valid_out   = 1'b1;
          end
        end
        default: stall = 1'b1;  // UPDATE
      endcase
    end
  end

endmodule
